// File: rtl/scale_half_pkg.sv
// Shared constants and width helpers for the 2x2 box-averaging downscaler.
//
// The channel width depends on the pixel depth mode:
//   half_depth == 0 -> 8-bit channels (24-bit pixel)
//   half_depth != 0 -> 4-bit channels (12-bit pixel)
// A horizontal pair sum needs one extra bit per channel. Three such sums are
// packed into one line-buffer word.
package scale_half_pkg;

  // Added before the divide-by-four so the average rounds to nearest.
  localparam int unsigned ROUND_CONST = 2;

  function automatic int unsigned chan_width(input int unsigned half_depth);
    return (half_depth != 0) ? 4 : 8;
  endfunction

  // Packed width of three (c+1)-bit pair sums.
  function automatic int unsigned sum_width(input int unsigned half_depth);
    return 3 * (chan_width(half_depth) + 1);
  endfunction

endpackage

// File: rtl/line_sum_ram.sv
// Line buffer holding the horizontal pair sums of the most recent even line.
//
// Simple dual-port memory: one write port, one synchronous read port with a
// single clock of read latency. The read register only updates when re is
// high, so read data stays put until the next read. Contents are never reset.
//
// Ports:
//   clk    sole clock
//   we     write enable
//   waddr  write address (pair index)
//   wdata  packed three-channel pair sum
//   re     read enable
//   raddr  read address (pair index)
//   rdata  read data, valid the clock after re
module line_sum_ram #(
  parameter int unsigned DEPTH = 384,
  parameter int unsigned WIDTH = 27,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/scale_half.sv
// 2x2 box-averaging downscaler: halves a pixel stream in both directions.
//
// Even lines: each horizontal pixel pair is summed per channel and the sum is
// stored in the line buffer. Odd lines: the pair sum is added to the stored
// sum of the pair above, rounded and divided by four, and emitted.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high
//   ce_in        input pixel strobe (at least one idle clock between strobes)
//   pixel_in     input pixel, three channels packed high to low
//   reset_line   high during horizontal blank; falling edge starts a line
//   reset_frame  high during vertical blank
//   out_valid    one-clock pulse per output pixel
//   out_pixel    averaged pixel, same packing as pixel_in
//   out_x        output column (input pair index)
module scale_half
  import scale_half_pkg::*;
#(
  parameter  int unsigned LENGTH     = 768,
  parameter  int unsigned HALF_DEPTH = 0,
  localparam int unsigned DWIDTH     = (HALF_DEPTH != 0) ? 11 : 23,
  localparam int unsigned XW         = $clog2(LENGTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce_in,
  input  logic [DWIDTH:0] pixel_in,
  input  logic            reset_line,
  input  logic            reset_frame,
  output logic            out_valid,
  output logic [DWIDTH:0] out_pixel,
  output logic [XW-2:0]   out_x
);

  localparam int unsigned CW    = chan_width(HALF_DEPTH);
  localparam int unsigned SW    = sum_width(HALF_DEPTH);
  localparam int unsigned DEPTH = LENGTH / 2;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // x is one bit wider than XW so it can hold LENGTH itself when saturated.
  localparam logic [XW:0] X_LIMIT = (XW + 1)'(LENGTH);

  // State
  logic            rl_q;        // reset_line as last sampled on a strobe
  logic            frame_q;     // reset_frame seen high since the last line start
  logic            y_odd_q;
  logic [XW:0]     x_q;
  logic [DWIDTH:0] px_hold_q;
  logic [SW-1:0]   hsum_q;
  logic [XW-2:0]   pair_x_q;
  logic            pair_q;      // odd-line pair sum ready for the vertical add

  // Next-state / datapath
  logic            line_start;
  logic            frame_force;
  logic            frame_d;
  logic [XW:0]     x_eff;
  logic [XW:0]     x_d;
  logic            y_eff;
  logic            accept;
  logic            even_px;
  logic            odd_px;
  logic [AW-1:0]   pair_addr;
  logic [SW-1:0]   hsum_c;
  logic [SW-1:0]   rd_sum;
  logic [DWIDTH:0] avg;

  // Line control. The strobe that sees the falling edge of reset_line also
  // carries the first pixel of the line, so x and y_odd are taken from their
  // "effective" values for that same cycle.
  always_comb begin
    line_start  = ce_in & rl_q & ~reset_line;
    // A line starting after vertical blank is always the first (even) line.
    frame_force = line_start & frame_q & ~reset_frame;

    frame_d = frame_q;
    if (ce_in) begin
      if (reset_frame) begin
        frame_d = 1'b1;
      end else if (line_start) begin
        frame_d = 1'b0;
      end
    end

    x_eff = line_start ? '0 : x_q;
    y_eff = y_odd_q;
    if (line_start) begin
      y_eff = frame_force ? 1'b0 : ~y_odd_q;
    end

    accept  = ce_in & ~reset_line & (x_eff < X_LIMIT);
    even_px = accept & ~x_eff[0];
    odd_px  = accept & x_eff[0];

    x_d       = accept ? (x_eff + (XW + 1)'(1)) : x_eff;
    pair_addr = x_eff[AW:1];
  end

  // Per-channel arithmetic. Pair sums carry one extra bit; the 2x2 total of
  // two pair sums plus rounding fits in c+2 bits, and dropping the low two
  // bits leaves a value no larger than the channel maximum.
  for (genvar g = 0; g < 3; g++) begin : g_chan
    logic [CW+1:0] total;

    assign hsum_c[g*(CW+1) +: CW+1] = {1'b0, px_hold_q[g*CW +: CW]}
                                    + {1'b0, pixel_in[g*CW +: CW]};

    assign total = {1'b0, hsum_q[g*(CW+1) +: CW+1]}
                 + {1'b0, rd_sum[g*(CW+1) +: CW+1]}
                 + (CW + 2)'(ROUND_CONST);

    assign avg[g*CW +: CW] = total[CW+1:2];
  end

  // Even lines write the pair sum; odd lines fetch the pair above when the
  // first pixel of the pair arrives, so data is ready before the second one.
  line_sum_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SW),
    .AW    (AW)
  ) u_line_sum_ram (
    .clk   (clk),
    .we    (odd_px & ~y_eff),
    .waddr (pair_addr),
    .wdata (hsum_c),
    .re    (even_px & y_eff),
    .raddr (pair_addr),
    .rdata (rd_sum)
  );

  // Line/column state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rl_q      <= 1'b0;
      frame_q   <= 1'b0;
      y_odd_q   <= 1'b0;
      x_q       <= '0;
      px_hold_q <= '0;
    end else begin
      if (ce_in) begin
        rl_q <= reset_line;
      end
      frame_q <= frame_d;
      y_odd_q <= y_eff;
      x_q     <= x_d;
      if (even_px) begin
        px_hold_q <= pixel_in;
      end
    end
  end

  // Horizontal sum stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsum_q   <= '0;
      pair_x_q <= '0;
      pair_q   <= 1'b0;
    end else begin
      pair_q <= odd_px & y_eff;
      if (odd_px) begin
        hsum_q   <= hsum_c;
        pair_x_q <= x_eff[XW-1:1];
      end
    end
  end

  // Output stage; a pair already past the horizontal sum completes even if a
  // new line starts meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_x     <= '0;
    end else begin
      out_valid <= pair_q;
      if (pair_q) begin
        out_pixel <= avg;
        out_x     <= pair_x_q;
      end
    end
  end

endmodule

// File: tb/tb_scale_half.sv
// Bench for scale_half: a 24-bit and a 12-bit instance share line/frame
// controls; each has its own pixel input and its own scoreboard queue.
module tb_scale_half;

  localparam int unsigned LEN = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        reset_line = 1'b0;
  logic        reset_frame = 1'b0;
  logic [23:0] pix0 = '0;
  logic [11:0] pix1 = '0;
  logic        out_valid0, out_valid1;
  logic [23:0] out_pixel0;
  logic [11:0] out_pixel1;
  logic [1:0]  out_x0, out_x1;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int vcnt0 = 0;
  int vcnt1 = 0;

  typedef struct {
    int          cyc;
    int          x;
    logic [23:0] pix;
  } sb_t;
  sb_t q0[$];
  sb_t q1[$];

  typedef struct packed {
    logic        hd;
    logic [23:0] a, b, c, d, e;
  } vec_t;
  vec_t vecs[9];

  scale_half #(.LENGTH(LEN), .HALF_DEPTH(0)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .ce_in       (ce),
    .pixel_in    (pix0),
    .reset_line  (reset_line),
    .reset_frame (reset_frame),
    .out_valid   (out_valid0),
    .out_pixel   (out_pixel0),
    .out_x       (out_x0)
  );

  scale_half #(.LENGTH(LEN), .HALF_DEPTH(1)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .ce_in       (ce),
    .pixel_in    (pix1),
    .reset_line  (reset_line),
    .reset_frame (reset_frame),
    .out_valid   (out_valid1),
    .out_pixel   (out_pixel1),
    .out_x       (out_x1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Output appears two clocks after the strobe that completes an odd-line pair.
  task automatic strobe(input logic rl, input logic rf, input logic [23:0] p0,
                        input logic [11:0] p1, input bit push, input logic [23:0] e0,
                        input logic [11:0] e1, input int ex);
    @(negedge clk);
    ce = 1'b1;
    reset_line = rl;
    reset_frame = rf;
    pix0 = p0;
    pix1 = p1;
    if (push) begin
      q0.push_back('{cyc + 2, ex, e0});
      q1.push_back('{cyc + 2, ex, {12'h0, e1}});
    end
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic blank(input logic rf);
    strobe(1'b1, rf, 24'h0, 12'h0, 1'b0, 24'h0, 12'h0, 0);
  endtask

  task automatic px(input logic [23:0] p0, input logic [11:0] p1);
    strobe(1'b0, 1'b0, p0, p1, 1'b0, 24'h0, 12'h0, 0);
  endtask

  task automatic pxo(input logic [23:0] p0, input logic [11:0] p1, input logic [23:0] e0,
                     input logic [11:0] e1, input int ex);
    strobe(1'b0, 1'b0, p0, p1, 1'b1, e0, e1, ex);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " valid0"}, 32'(out_valid0), 32'h0);
    check({tag, " pixel0"}, 32'(out_pixel0), 32'h0);
    check({tag, " x0"}, 32'(out_x0), 32'h0);
    check({tag, " valid1"}, 32'(out_valid1), 32'h0);
    check({tag, " pixel1"}, 32'(out_pixel1), 32'h0);
    check({tag, " x1"}, 32'(out_x1), 32'h0);
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (out_valid0 === 1'b1) begin
        vcnt0++;
        check("sb0 expected output", 32'(q0.size() != 0), 32'h1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("sb0 pixel", 32'(out_pixel0), 32'(e.pix));
          check("sb0 x", 32'(out_x0), 32'(e.x));
          check("sb0 cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (out_valid1 === 1'b1) begin
        vcnt1++;
        check("sb1 expected output", 32'(q1.size() != 0), 32'h1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("sb1 pixel", 32'(out_pixel1), 32'(e.pix));
          check("sb1 x", 32'(out_x1), 32'(e.x));
          check("sb1 cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   c0, c1;

    // hd, even pair a b, odd pair c d, expected average
    vecs[0] = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFF};
    vecs[1] = '{1'b0, 24'h000001, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
    vecs[2] = '{1'b0, 24'h000002, 24'h000000, 24'h000000, 24'h000000, 24'h000001};
    vecs[3] = '{1'b0, 24'h102030, 24'h0F0E0D, 24'hFF0001, 24'h800080, 24'h680C30};
    vecs[4] = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    vecs[5] = '{1'b1, 24'h000F00, 24'h000F00, 24'h000F00, 24'h000F00, 24'h000F00};
    vecs[6] = '{1'b1, 24'h00000F, 24'h00000F, 24'h00000F, 24'h00000F, 24'h00000F};
    vecs[7] = '{1'b1, 24'h000123, 24'h000456, 24'h000789, 24'h000ABC, 24'h000678};
    vecs[8] = '{1'b1, 24'h000FFF, 24'h000FFF, 24'h000FFF, 24'h000FFE, 24'h000FFF};

    fork
      monitor();
    join_none

    // Reset state
    idle(3);
    check_outputs_zero("reset");
    reset = 1'b0;

    // 2x2 table vectors, each as its own frame
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      blank(1'b1);
      px(v.hd ? 24'h0 : v.a, v.hd ? v.a[11:0] : 12'h0);
      px(v.hd ? 24'h0 : v.b, v.hd ? v.b[11:0] : 12'h0);
      blank(1'b0);
      px(v.hd ? 24'h0 : v.c, v.hd ? v.c[11:0] : 12'h0);
      pxo(v.hd ? 24'h0 : v.d, v.hd ? v.d[11:0] : 12'h0,
          v.hd ? 24'h0 : v.e, v.hd ? v.e[11:0] : 12'h0, 0);
    end
    idle(4);

    // Four-pixel gray lines
    blank(1'b1);
    px(24'h0A0A0A, 12'h0); px(24'h141414, 12'h0); px(24'h1E1E1E, 12'h0); px(24'h282828, 12'h0);
    blank(1'b0);
    px(24'h1E1E1E, 12'h0); pxo(24'h282828, 12'h0, 24'h191919, 12'h0, 0);
    px(24'h323232, 12'h0); pxo(24'h3C3C3C, 12'h0, 24'h2D2D2D, 12'h0, 1);
    idle(4);

    // Five-pixel lines: trailing pixel dropped, exactly two outputs
    c0 = vcnt0;
    blank(1'b1);
    for (int i = 0; i < 5; i++) px(24'h404040, 12'h0);
    blank(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 3) pxo(24'h808080, 12'h0, 24'h606060, 12'h0, i / 2);
      else px(24'h808080, 12'h0);
    end
    idle(4);
    check("odd5 pulse count", 32'(vcnt0 - c0), 32'd2);

    // Three-line frame, then a frame whose first line follows an even line
    c0 = vcnt0;
    blank(1'b1);
    px(24'h101010, 12'h0); px(24'h101010, 12'h0);
    blank(1'b0);
    px(24'h202020, 12'h0); pxo(24'h202020, 12'h0, 24'h181818, 12'h0, 0);
    blank(1'b0);
    px(24'h303030, 12'h0); px(24'h303030, 12'h0);
    blank(1'b1);
    px(24'h505050, 12'h0); px(24'h505050, 12'h0);
    idle(4);
    check("frame lines 1-4 pulse count", 32'(vcnt0 - c0), 32'd1);
    blank(1'b0);
    px(24'h707070, 12'h0); pxo(24'h707070, 12'h0, 24'h606060, 12'h0, 0);
    idle(4);

    // Line restart mid-pair: held pixel discarded, column restarts at 0
    blank(1'b1);
    for (int i = 0; i < 4; i++) px(24'h040404, 12'h0);
    blank(1'b0);
    px(24'h080808, 12'h0); pxo(24'h080808, 12'h0, 24'h060606, 12'h0, 0);
    px(24'h080808, 12'h0);
    blank(1'b0);
    px(24'h101010, 12'h0); px(24'h202020, 12'h0);
    blank(1'b0);
    px(24'h000000, 12'h0); pxo(24'h000000, 12'h0, 24'h0C0C0C, 12'h0, 0);
    idle(4);

    // Over-length lines: x saturates, pixels past LEN ignored
    c1 = vcnt1;
    blank(1'b1);
    for (int i = 0; i < 10; i++) px(24'h080808, 12'h0);
    blank(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1 && i < 8) pxo(24'h0C0C0C, 12'h0, 24'h0A0A0A, 12'h0, i / 2);
      else px(24'h0C0C0C, 12'h0);
    end
    idle(4);
    check("saturate pulse count", 32'(vcnt1 - c1), 32'd4);

    // Reset one clock after the completing strobe suppresses the output
    blank(1'b1);
    px(24'h111111, 12'h111); px(24'h111111, 12'h111);
    blank(1'b0);
    px(24'h222222, 12'h222);
    c0 = vcnt0;
    c1 = vcnt1;
    @(negedge clk);
    ce = 1'b1;
    reset_line = 1'b0;
    pix0 = 24'h222222;
    pix1 = 12'h222;
    @(negedge clk);
    ce = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs_zero("in reset");
    end
    reset = 1'b0;
    idle(3);
    check("reset suppress dut0", 32'(vcnt0 - c0), 32'd0);
    check("reset suppress dut1", 32'(vcnt1 - c1), 32'd0);

    check("sb0 drained", 32'(q0.size()), 32'd0);
    check("sb1 drained", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scale_half.md
SCALE_HALF -- requirements
Module: scale_half

Interface
REQ-001 SHALL have parameter LENGTH, default 768: maximum input pixels per line.
REQ-002 SHALL have parameter HALF_DEPTH, default 0: 0 = 24-bit pixel (three 8-bit channels), 1 = 12-bit pixel (three 4-bit channels).
REQ-003 SHALL define DWIDTH = HALF_DEPTH ? 11 : 23, XW = $clog2(LENGTH).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ce_in  in  1  input pixel strobe; environment guarantees ≥1 idle clk between strobes.
REQ-007 pixel_in  in  DWIDTH+1  input pixel; channels at [DWIDTH:DWIDTH-c+1], middle, [c-1:0] (c = channel width).
REQ-008 reset_line  in  1  high during horizontal blank; falling edge starts a line.
REQ-009 reset_frame  in  1  high during vertical blank.
REQ-010 out_valid  out  1  one-clk pulse per output pixel.
REQ-011 out_pixel  out  DWIDTH+1  2x2 box-averaged pixel, same packing as pixel_in.
REQ-012 out_x  out  XW-1  output pixel column (input pair index).

Function
REQ-013 SHALL sample reset_line and reset_frame only on ce_in cycles.
REQ-014 Falling edge of sampled reset_line SHALL zero column counter x, discard any held half-pair, toggle line phase y_odd.
REQ-015 If reset_frame was high at the previous line start and is low at this one, y_odd SHALL be forced to 0 (first active line even) instead of toggling.
REQ-016 Pixels with ce_in while sampled reset_line high SHALL be ignored.
REQ-017 Each accepted pixel SHALL increment x; x SHALL saturate at LENGTH, pixels at x ≥ LENGTH ignored.
REQ-018 Even x: pixel SHALL be held in px_hold; on odd lines, line-buffer read SHALL be issued at address x>>1.
REQ-019 Odd x: per-channel hsum = px_hold + pixel_in, width c+1, no overflow.
REQ-020 Even lines: hsum SHALL be written to the line buffer at address x>>1; no output produced.
REQ-021 Odd lines: per channel, out = (hsum + buffered_sum + 2) >> 2, width c, result ≤ max channel value.
REQ-022 Output latency: out_valid SHALL be high exactly one clk, 2 clks after the ce_in cycle accepting the odd-x pixel; out_pixel/out_x stable until next out_valid.
REQ-023 out_x SHALL equal x>>1 of the completing pair.
REQ-024 Trailing unpaired pixel (odd line length) SHALL be dropped; trailing unpaired even line at frame end produces no output.
REQ-025 Odd line longer than preceding even line SHALL read stale buffer contents (no special handling).
REQ-026 reset_line falling mid-pair SHALL cancel the pair; an in-flight output already past hsum SHALL still complete.

Reset
REQ-027 reset SHALL asynchronously clear x, y_odd, px_hold, hsum, out_valid, out_pixel, out_x and both edge-detect registers to 0.
REQ-028 Line buffer contents SHALL NOT be reset; first odd line after reset outputs only after an even line is written.
REQ-029 reset asserted mid-line SHALL suppress any pending out_valid.

Structure
REQ-030 Package scale_half_pkg SHALL hold channel-width function of HALF_DEPTH, rounding constant 2, and packed sum-word width 3*(c+1).
REQ-031 Sub-module line_sum_ram SHALL implement LENGTH/2 words of 3*(c+1) bits, one write port, one synchronous read port, 1-clk read latency, inferred block RAM.
REQ-032 Remaining logic (counters, edge detect, adders, output registers) SHALL reside in scale_half.

Verification
REQ-033 HALF_DEPTH=0, 4-pixel lines: even line 10,20,30,40 (gray), odd line 30,40,50,60 -> out_x 0 = 0x191919 (25), out_x 1 = 0x2D2D2D (45).
REQ-034 Rounding: 2x2 all 0xFF except one 0xFE -> 0xFF; values 1,0,0,0 -> 0x00; 2,0,0,0 -> 0x01.
REQ-035 HALF_DEPTH=1: all four 0xF00 -> 0xF00, no channel leakage; four 0x00F -> 0x00F.
REQ-036 5-pixel odd line, ce_in every 2 clks -> exactly 2 out_valid pulses, each 2 clks after 2nd/4th odd-line pixel strobe.
REQ-037 reset_frame falling between lines -> next line even (no output), following line outputs; three-line frame -> outputs only on line 2.
REQ-038 reset asserted 1 clk after odd-pixel strobe -> no out_valid; all outputs 0 while reset high.
